ray_stepper_2d: RTL and testbench
=================================

// Module: ray_stepper_2d
// PURPOSE
//  Walks a 2D ray from a start pixel along the direction vector produced by two_d_normalize.
//  Emits one sample point per cycle over a valid/ready stream to the downstream pixel/voxel test stage.
//  Accepts one ray at a time. A ray ends after in_steps+1 samples, or at the first out-of-bounds sample.
// PARAMETERS
//  POS_W   20   width of two's-complement position accumulators and out_x/out_y
//  WIDTH   640  screen width;  valid x range 0..WIDTH-1
//  HEIGHT  480  screen height; valid y range 0..HEIGHT-1
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      ray descriptor valid
//  in_ready   out  1      stepper idle, can accept a ray
//  in_start_x in   11     start x, unsigned pixel coordinate
//  in_start_y in   11     start y, unsigned pixel coordinate
//  in_dir     in   22     {x[21:11], y[10:0]}, each sign-magnitude: bit10 = sign, [9:0] = magnitude
//  in_steps   in   8      step count N; ray yields N+1 samples
//  out_valid  out  1      sample valid
//  out_ready  in   1      downstream accepts sample
//  out_x      out  POS_W  sample x, two's complement
//  out_y      out  POS_W  sample y, two's complement
//  out_last   out  1      final sample of this ray
//  out_oob    out  1      this sample lies outside the screen; implies out_last
// BEHAVIOUR
//  Reset values: in_ready=0 during rst, then 1 from the first cycle after rst deasserts.
//   out_valid=0; out_x=out_y=0; out_last=out_oob=0; state=IDLE; k=0.
//  Two states:
//   IDLE: in_ready=1, out_valid=0.
//   EMIT: in_ready=0, out_valid=1.
//  IDLE, in_valid&in_ready:
//   - zero-extend the start point into pos.
//   - convert both dir components to two's complement, sign-extended to POS_W, into dx/dy.
//   - latch N; clear k; go to EMIT.
//   - out_valid rises the next cycle. Latency = 1 cycle.
//  Sample k is start + k*dir, for k = 0..N. Sample 0 is the start point itself.
//  out_last=1 when k==N or out_oob=1.
//  out_oob=1 when x<0, x>=WIDTH, y<0 or y>=HEIGHT, using signed compares on the registered sample.
//  Bounds flags are registered with the sample. The combinational path from pos to out_* must not depend on out_ready.
//  EMIT, out_valid&out_ready:
//   - not last: pos += (dx,dy), k += 1; the next sample is presented the following cycle.
//   - last: go to IDLE. in_ready=1 the following cycle; no overlap of rays.
//   - Throughput is 1 sample/cycle with out_ready held high.
//  EMIT, out_valid&!out_ready: out_x, out_y, out_last, out_oob held bit-stable. No accumulation.
//  Sign-magnitude conversion: negative zero (sign=1, mag=0) converts to 0. Range is -1023..+1023.
//  Arithmetic wraps mod 2^POS_W. Overflow is impossible at the default POS_W:
//   max excursion 2047 + 255*1023 < 2^19.
//  N=0: exactly one sample, the start point, with out_last=1.
//  A start point outside the screen makes sample 0 carry out_oob=1 and out_last=1.
//  in_valid while in EMIT: ignored (in_ready=0). The upstream holds the descriptor.
//  rst mid-ray: drops the ray. No further samples. State as reset.
//  An out-of-range sample is still emitted (with oob). Nothing is emitted after it.
// STRUCTURE
//  Shared header vtracer_defs.vh:
//   - DIR_W=11 and SM_SIGN=10
//   - DIR_X_HI/LO, DIR_Y_HI/LO field positions of the packed 22-bit dir
//   - STEP_W=8
//   - state encodings ST_IDLE/ST_EMIT
//  Sub-module sm_to_twos (#LENGTH, OUT_W): combinational sign-magnitude to two's-complement converter.
//   Instantiated twice, for x and y.
//  The top level holds the FSM, the k counter, the pos/dx/dy registers, and the bounds compare.
// TESTING
//  1. start(10,20), dir x=11'h003 y=11'h402, N=3, out_ready=1
//     -> (10,20) (13,18) (16,16) (19,14) on 4 consecutive cycles; last only on 4th; oob=0; in_ready=1 next cycle.
//  2. Same ray, out_ready=0 for 5 cycles while sample (13,18) is presented
//     -> out_valid=1 and (13,18) held all 5 cycles; (16,16) appears 1 cycle after out_ready returns.
//  3. start(630,5), dir x=11'h004 y=11'h000, N=10
//     -> (630,5) (634,5) (638,5) (642,5); the 4th has oob=1 and last=1; exactly 4 samples.
//  4. N=0 with start(0,0), dir x=11'h400 y=11'h7FF
//     -> single sample (0,0), last=1, oob=0. Then start(0,0), dir y=11'h401, N=1
//     -> (0,0) then (0,-1) with oob=1.
//  5. rst asserted for 1 cycle while sample k=2 is presented
//     -> out_valid=0 the cycle after; in_ready=1 after rst drops; the next ray runs from k=0 uncorrupted.
//  6. in_valid held high with a second ray during EMIT
//     -> not accepted until the cycle after the first ray's last handshake; the second ray's sample 0 appears 1 cycle later.

Source files
------------

// File: rtl/ray_stepper_2d_pkg.sv
// rtl/ray_stepper_2d_pkg.sv - shared field positions, widths and state encoding for the ray stepper
package ray_stepper_2d_pkg;

    localparam int DIR_W    = 11;
    localparam int SM_SIGN  = 10;
    localparam int DIR_X_HI = 21;
    localparam int DIR_X_LO = 11;
    localparam int DIR_Y_HI = 10;
    localparam int DIR_Y_LO = 0;
    localparam int STEP_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/sm_to_twos.sv
// rtl/sm_to_twos.sv - combinational sign-magnitude to sign-extended two's-complement converter
module sm_to_twos #(
    parameter int LENGTH = 11,
    parameter int OUT_W  = 20
) (
    input  logic [LENGTH-1:0] sm_i,
    output logic [OUT_W-1:0]  tw_o
);

    logic [OUT_W-1:0] mag_ext;

    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    always_comb begin
        mag_ext = {{(OUT_W-LENGTH+1){1'b0}}, sm_i[LENGTH-2:0]};
        tw_o    = sm_i[LENGTH-1] ? (~mag_ext + 1'b1) : mag_ext;
    end

endmodule

// File: rtl/ray_stepper_2d.sv
// rtl/ray_stepper_2d.sv - walks a 2D ray from a start pixel, one bounds-tagged sample per cycle
module ray_stepper_2d
    import ray_stepper_2d_pkg::*;
#(
    parameter int POS_W  = 20,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_start_x,
    input  logic [10:0]       in_start_y,
    input  logic [21:0]       in_dir,
    input  logic [7:0]        in_steps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  out_x,
    output logic [POS_W-1:0]  out_y,
    output logic              out_last,
    output logic              out_oob
);

    localparam logic signed [POS_W-1:0] W_S = POS_W'(WIDTH);
    localparam logic signed [POS_W-1:0] H_S = POS_W'(HEIGHT);

    state_e              state_q;
    logic [STEP_W-1:0]   k_q, n_q, k_d;
    logic [POS_W-1:0]    x_q, y_q, dx_q, dy_q;
    logic [POS_W-1:0]    x_d, y_d, dx_c, dy_c;
    logic                last_q, oob_q, oob_d;

    sm_to_twos #(.LENGTH(DIR_W), .OUT_W(POS_W)) u_cvt_x (
        .sm_i (in_dir[DIR_X_HI:DIR_X_LO]),
        .tw_o (dx_c)
    );

    sm_to_twos #(.LENGTH(DIR_W), .OUT_W(POS_W)) u_cvt_y (
        .sm_i (in_dir[DIR_Y_HI:DIR_Y_LO]),
        .tw_o (dy_c)
    );

    // Candidate next sample: the start point when idle, otherwise one step along the ray.
    always_comb begin
        x_d   = (state_q == ST_IDLE) ? {{(POS_W-11){1'b0}}, in_start_x} : x_q + dx_q;
        y_d   = (state_q == ST_IDLE) ? {{(POS_W-11){1'b0}}, in_start_y} : y_q + dy_q;
        k_d   = k_q + 1'b1;
        oob_d = ($signed(x_d) < 0) || ($signed(x_d) >= W_S) ||
                ($signed(y_d) < 0) || ($signed(y_d) >= H_S);
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_EMIT);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_last  = last_q;
    assign out_oob   = oob_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            last_q  <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        dx_q    <= dx_c;
                        dy_q    <= dy_c;
                        n_q     <= in_steps;
                        k_q     <= '0;
                        oob_q   <= oob_d;
                        last_q  <= (in_steps == '0) || oob_d;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            x_q    <= x_d;
                            y_q    <= y_d;
                            k_q    <= k_d;
                            oob_q  <= oob_d;
                            last_q <= (k_d == n_q) || oob_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_stepper_2d.sv
// tb/tb_ray_stepper_2d.sv - directed self-checking bench for ray_stepper_2d
module tb_ray_stepper_2d;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_start_x;
    logic [10:0] in_start_y;
    logic [21:0] in_dir;
    logic [7:0]  in_steps;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_x;
    logic [19:0] out_y;
    logic        out_last;
    logic        out_oob;

    int tests = 0;
    int fails = 0;

    ray_stepper_2d #(.POS_W(20), .WIDTH(640), .HEIGHT(480)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_start_x (in_start_x),
        .in_start_y (in_start_y),
        .in_dir     (in_dir),
        .in_steps   (in_steps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .out_oob    (out_oob)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input string tag, input int ex, input int ey, input logic el, input logic eo);
        logic [19:0] exv, eyv;
        exv = ex[19:0];
        eyv = ey[19:0];
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_x"}, {12'b0, out_x}, {12'b0, exv});
        chk({tag, "_y"}, {12'b0, out_y}, {12'b0, eyv});
        chk({tag, "_last"}, {31'b0, out_last}, {31'b0, el});
        chk({tag, "_oob"}, {31'b0, out_oob}, {31'b0, eo});
        @(negedge clk);
    endtask

    task automatic send(input int sx, input int sy, input logic [21:0] d, input int n, input bit hold);
        int t;
        in_start_x = sx[10:0];
        in_start_y = sy[10:0];
        in_dir     = d;
        in_steps   = n[7:0];
        in_valid   = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            tests++;
            fails++;
            $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_ov"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_start_x = '0; in_start_y = '0;
        in_dir = '0; in_steps = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_x", {12'b0, out_x}, 32'd0);
        chk("rst_out_y", {12'b0, out_y}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        chk("rst_oob", {31'b0, out_oob}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // 1: basic walk, x+3 y-2
        send(10, 20, {11'h003, 11'h402}, 3, 1'b0);
        smp("t1_s0", 10, 20, 1'b0, 1'b0);
        smp("t1_s1", 13, 18, 1'b0, 1'b0);
        smp("t1_s2", 16, 16, 1'b0, 1'b0);
        smp("t1_s3", 19, 14, 1'b1, 1'b0);
        idle_chk("t1_end");

        // 2: backpressure on sample 1
        send(10, 20, {11'h003, 11'h402}, 3, 1'b0);
        smp("t2_s0", 10, 20, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t2_hold_x", {12'b0, out_x}, 32'd13);
            chk("t2_hold_y", {12'b0, out_y}, 32'd18);
            chk("t2_hold_last", {31'b0, out_last}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        smp("t2_s2", 16, 16, 1'b0, 1'b0);
        smp("t2_s3", 19, 14, 1'b1, 1'b0);
        idle_chk("t2_end");

        // 3: exits the right edge
        send(630, 5, {11'h004, 11'h000}, 10, 1'b0);
        smp("t3_s0", 630, 5, 1'b0, 1'b0);
        smp("t3_s1", 634, 5, 1'b0, 1'b0);
        smp("t3_s2", 638, 5, 1'b0, 1'b0);
        smp("t3_s3", 642, 5, 1'b1, 1'b1);
        idle_chk("t3_end");

        // 4: N=0, then exit through the top edge
        send(0, 0, {11'h400, 11'h7FF}, 0, 1'b0);
        smp("t4a_s0", 0, 0, 1'b1, 1'b0);
        idle_chk("t4a_end");
        send(0, 0, {11'h000, 11'h401}, 1, 1'b0);
        smp("t4b_s0", 0, 0, 1'b0, 1'b0);
        smp("t4b_s1", 0, -1, 1'b1, 1'b1);
        idle_chk("t4b_end");

        // 5: reset mid-ray
        send(10, 20, {11'h003, 11'h402}, 3, 1'b0);
        smp("t5_s0", 10, 20, 1'b0, 1'b0);
        smp("t5_s1", 13, 18, 1'b0, 1'b0);
        chk("t5_k2_x", {12'b0, out_x}, 32'd16);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ov", {31'b0, out_valid}, 32'd0);
        chk("t5_rst_rdy", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_post_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("t5_idle_ov", {31'b0, out_valid}, 32'd0);
        send(10, 20, {11'h003, 11'h402}, 3, 1'b0);
        smp("t5r_s0", 10, 20, 1'b0, 1'b0);
        smp("t5r_s1", 13, 18, 1'b0, 1'b0);
        smp("t5r_s2", 16, 16, 1'b0, 1'b0);
        smp("t5r_s3", 19, 14, 1'b1, 1'b0);

        // 6: second ray held on in_valid during EMIT
        send(10, 20, {11'h003, 11'h402}, 3, 1'b1);
        in_start_x = 11'd100;
        in_start_y = 11'd100;
        in_dir     = {11'h001, 11'h001};
        in_steps   = 8'd1;
        chk("t6_busy_rdy", {31'b0, in_ready}, 32'd0);
        smp("t6a_s0", 10, 20, 1'b0, 1'b0);
        smp("t6a_s1", 13, 18, 1'b0, 1'b0);
        chk("t6_busy_rdy2", {31'b0, in_ready}, 32'd0);
        smp("t6a_s2", 16, 16, 1'b0, 1'b0);
        smp("t6a_s3", 19, 14, 1'b1, 1'b0);
        idle_chk("t6_gap");
        @(negedge clk);
        in_valid = 1'b0;
        smp("t6b_s0", 100, 100, 1'b0, 1'b0);
        smp("t6b_s1", 101, 101, 1'b1, 1'b0);
        idle_chk("t6_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
